rc5_key_schedule: RTL and testbench
===================================

Name: rc5_key_schedule

Overview:
- RC5-32/12/16 key-expansion stage, directly upstream of the decipher datapath.
- Takes a 128-bit user key and runs the full RC5 schedule: L load, S init, 3*max(T,C) mixing passes.
- Streams every S-table write out on a RAM write port, so the downstream S RAM ends up holding the final expanded table.
- Pulses done when the table is complete; the decipher stage may start only after that.

Parameters:
- W, 32: word width in bits; fixed at 32, rotate amount uses W[4:0].
- R, 12: round count; T = 2*(R+1) = 26 S entries.
- B, 16: key bytes; C = B/4 = 4 L words.
- T_LEN, 5: S address width, clog2(T).

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin expansion; sampled only in IDLE.
- key  in  8*B  user key; byte i = key[8i+:8], little-endian.
- s_we  out  1  S RAM write enable.
- s_addr  out  T_LEN  S RAM write address.
- s_wdata  out  W  S RAM write data.
- busy  out  1  high from LOAD through MIX.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; s_we=0, s_addr=0, s_wdata=0, busy=0, done=0.
  - Internal A, B, i, j, counters cleared.
  - Applies mid-operation too: the next cycle is IDLE and no further writes occur.
- Internal storage: S[0..T-1] and L[0..C-1] registers. The block never reads the downstream RAM.
- Outputs s_we, s_addr, s_wdata are combinational from current state and registers. The downstream RAM captures them on the next edge.
- IDLE:
  - start=1 goes to LOAD. key is captured on the same edge.
- LOAD (1 cycle):
  - L[k] = key[32k+:32] for k=0..C-1. No write.
- INIT (T cycles, index i=0..T-1):
  - S[i] = 0xB7E15163 + i*0x9E3779B9, mod 2^32.
  - s_we=1, s_addr=i, s_wdata=S[i].
- MIX (3*max(T,C)=78 cycles, one iteration per cycle). Starts with A=B=0, i=0, j=0:
  - Anew = rotl(S[i]+A+B, 3); written to S[i].
  - Bnew = rotl(L[j]+Anew+B, (Anew+B) mod 32); written to L[j].
  - s_we=1, s_addr=i, s_wdata=Anew.
  - i wraps at T to 0; j wraps at C to 0. Both wrap in the same cycle when coincident.
- DONE (1 cycle):
  - done=1, s_we=0, busy=0. Returns to IDLE unconditionally.
- Timing:
  - start sampled at edge E0 gives LOAD after E0 and INIT after E0+1.
  - Last MIX write is presented in the cycle before E0+105; done=1 in the cycle after E0+105.
  - Exactly 104 write cycles per run.
- start while busy or in DONE: ignored, no restart.
- All sums truncate to 32 bits. A rotate by 0 leaves the value unchanged.
- key changes after the start-sampling edge have no effect on the run.

Optional Feature:
- RC5_KEY_ZEROIZE_EN defined:
  - An extra ZERO state sits between MIX and DONE. It clears L[0..C-1], A and B to 0, with s_we=0.
  - done is delayed by 1 cycle, to the cycle after E0+106.
- Undefined: L, A and B keep their final values until the next run or reset.

Test Plan:
- Reset check: rst=1 for 2 cycles with start=1 -> busy=0, done=0, s_we=0 throughout; no writes.
- Init sequence with key=0, start pulse: first 26 writes are addr0=0xB7E15163, addr1=0x5618CB1C, ... addr25=0x2B4C3474, with s_we=1 on each.
- First mix with key=0: write 27 is addr0, data 0xBF0A8B1D. Total writes=104; done is one cycle wide in the cycle after E0+105 (E0+106 with zeroize).
- Reference model with key=128'hFFFEEEE58684FFF05FFE493853000434: final downstream S[0..25] matches the C reference RC5 expansion word-for-word. Then run the decipher stage on A=10, B=20 and check the round-trip against encrypt.
- Start during busy: pulse start at MIX cycle 40 -> no restart, write count still 104, single done.
- Reset mid-MIX: rst at MIX cycle 10 -> s_we=0 next cycle, IDLE. A new start gives the full 104-write sequence with a correct final table.

Source files
------------

// File: rtl/rc5_key_schedule.sv
// rc5_key_schedule: RC5-32/12/16 key expansion streaming every S write to a RAM port.
// Define RC5_KEY_ZEROIZE_EN to add a ZERO state that clears L, A and B before done.
module rc5_key_schedule #(
  parameter int W = 32,
  parameter int R = 12,
  parameter int B = 16,
  parameter int T_LEN = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [8*B-1:0]   key,
  output logic             s_we,
  output logic [T_LEN-1:0] s_addr,
  output logic [W-1:0]     s_wdata,
  output logic             busy,
  output logic             done
);
  localparam int T = 2 * (R + 1);
  localparam int C = B / 4;
  localparam int J_LEN = $clog2(C);
  localparam int MIX_N = 3 * ((T > C) ? T : C);
  localparam int N_LEN = $clog2(MIX_N);
  localparam logic [W-1:0] P = 32'hB7E15163;
  localparam logic [W-1:0] Q = 32'h9E3779B9;
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] INIT = 3'd2;
  localparam logic [2:0] MIX  = 3'd3;
  localparam logic [2:0] ZERO = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
`ifdef RC5_KEY_ZEROIZE_EN
  localparam logic [2:0] POST = ZERO;
`else
  localparam logic [2:0] POST = DONE;
`endif

  logic [2:0]       state_q, state_d;
  logic [W-1:0]     s_q [T];
  logic [W-1:0]     l_q [C];
  logic [W-1:0]     a_q, b_q, a_new, b_new, ab, init_val;
  logic [T_LEN-1:0] i_q;
  logic [J_LEN-1:0] j_q;
  logic [N_LEN-1:0] n_q;
  logic             i_last, mix_last, in_mix, clr_ab;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [4:0] n);
    logic [2*W-1:0] t;
    t = {x, x} << n;
    return t[2*W-1:W];
  endfunction

  always_comb begin
    in_mix   = state_q == MIX;
    i_last   = i_q == T_LEN'(T - 1);
    mix_last = n_q == N_LEN'(MIX_N - 1);
    a_new    = rotl(s_q[i_q] + a_q + b_q, 5'd3);
    ab       = a_new + b_q;
    b_new    = rotl(l_q[j_q] + ab, ab[4:0]);
    init_val = P + Q * {{(W - T_LEN){1'b0}}, i_q};
    clr_ab   = state_q == LOAD || state_q == ZERO;
    state_d  = (state_q == IDLE) ? (start ? LOAD : IDLE)
             : (state_q == LOAD) ? INIT
             : (state_q == INIT) ? (i_last ? MIX : INIT)
             : in_mix            ? (mix_last ? POST : MIX)
             : (state_q == ZERO) ? DONE : IDLE;
    s_we     = state_q == INIT || in_mix;
    s_addr   = s_we ? i_q : '0;
    s_wdata  = (state_q == INIT) ? init_val : in_mix ? a_new : '0;
    busy     = state_q != IDLE && state_q != DONE;
    done     = state_q == DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= in_mix ? a_new : clr_ab ? '0 : a_q;
      b_q     <= in_mix ? b_new : clr_ab ? '0 : b_q;
      i_q     <= (state_q == LOAD || (s_we && i_last)) ? '0 : s_we ? i_q + 1'b1 : i_q;
      j_q     <= (state_q == LOAD || (in_mix && j_q == J_LEN'(C - 1))) ? '0 : in_mix ? j_q + 1'b1 : j_q;
      n_q     <= (state_q == LOAD || (in_mix && mix_last)) ? '0 : in_mix ? n_q + 1'b1 : n_q;
    end
  end

  // Key words go straight into L on the start edge, so later key changes cannot leak in.
  always_ff @(posedge clk) begin
    for (int k = 0; k < C; k++) begin
      if (state_q == IDLE && start) l_q[k] <= key[32*k +: 32];
      if (state_q == ZERO) l_q[k] <= '0;
    end
    if (in_mix) l_q[j_q] <= b_new;
    if (s_we) s_q[i_q] <= s_wdata;
  end
endmodule

// File: tb/tb_rc5_key_schedule.sv
// tb_rc5_key_schedule: scoreboard bench for rc5_key_schedule with an RC5 reference model.
module tb_rc5_key_schedule;
`ifdef RC5_KEY_ZEROIZE_EN
  localparam int DL = 106;
`else
  localparam int DL = 105;
`endif
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  typedef logic [31:0] tab_t [26];

  logic clk = 0, rst = 1, start = 0;
  logic [127:0] key = '0;
  logic s_we, busy, done;
  logic [4:0] s_addr;
  logic [31:0] s_wdata;
  wr_t exp_q[$], got_q[$];
  tab_t ram, ms;
  int tests = 0, fails = 0, cyc = 0, wr_cnt = 0, done_cnt = 0, done_cyc = -1;

  rc5_key_schedule dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (s_we) begin
      got_q.push_back({s_addr, s_wdata});
      ram[s_addr] = s_wdata;
      wr_cnt++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  function automatic logic [31:0] rl(input logic [31:0] x, input int n);
    n = n & 31;
    return n == 0 ? x : (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    n = n & 31;
    return n == 0 ? x : (x >> n) | (x << (32 - n));
  endfunction

  task automatic model(input logic [127:0] k);
    logic [31:0] l [4];
    logic [31:0] a, b;
    int i, j;
    exp_q.delete();
    for (int c = 0; c < 4; c++) l[c] = k[32*c +: 32];
    ms[0] = 32'hB7E15163;
    for (int x = 1; x < 26; x++) ms[x] = ms[x-1] + 32'h9E3779B9;
    for (int x = 0; x < 26; x++) exp_q.push_back({5'(x), ms[x]});
    a = 0; b = 0; i = 0; j = 0;
    for (int n = 0; n < 78; n++) begin
      a = rl(ms[i] + a + b, 3);
      ms[i] = a;
      b = rl(l[j] + a + b, int'((a + b) & 32'd31));
      l[j] = b;
      exp_q.push_back({5'(i), a});
      i = (i + 1) % 26;
      j = (j + 1) % 4;
    end
  endtask

  task automatic encrypt(input tab_t s, input logic [31:0] p0, p1, output logic [31:0] c0, c1);
    c0 = p0 + s[0];
    c1 = p1 + s[1];
    for (int r = 1; r <= 12; r++) begin
      c0 = rl(c0 ^ c1, int'(c1 & 32'd31)) + s[2*r];
      c1 = rl(c1 ^ c0, int'(c0 & 32'd31)) + s[2*r+1];
    end
  endtask

  task automatic decrypt(input tab_t s, input logic [31:0] c0, c1, output logic [31:0] p0, p1);
    p0 = c0; p1 = c1;
    for (int r = 12; r >= 1; r--) begin
      p1 = rr(p1 - s[2*r+1], int'(p0 & 32'd31)) ^ p0;
      p0 = rr(p0 - s[2*r], int'(p1 & 32'd31)) ^ p1;
    end
    p1 = p1 - s[1];
    p0 = p0 - s[0];
  endtask

  // One full run; start is re-pulsed on the cycles e0+p1 and e0+p2 (negative: never).
  task automatic run(input logic [127:0] k, input int p1, input int p2, output int e0);
    model(k);
    got_q.delete();
    wr_cnt = 0; done_cnt = 0; done_cyc = -1;
    @(negedge clk);
    key = k; start = 1;
    @(posedge clk);
    #1 e0 = cyc;
    start = 0; key = ~k;
    for (int t = 0; t < DL + 5; t++) begin
      @(negedge clk);
      start = (cyc == e0 + p1 || cyc == e0 + p2);
    end
    start = 0;
  endtask

  task automatic test_reset;
    rst = 1; start = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++;
      if ({busy, done, s_we, s_addr, s_wdata} !== '0) begin
        fails++;
        $display("FAIL reset_out[%0d] got busy=%b done=%b we=%b addr=%0d data=%h exp all 0", c, busy, done, s_we, s_addr, s_wdata);
      end
    end
    rst = 0; start = 0;
    repeat (3) @(negedge clk);
    tests++;
    if (wr_cnt !== 0) begin fails++; $display("FAIL reset_writes got %0d exp 0", wr_cnt); end
  endtask

  task automatic test_init_mix;
    int e0;
    wr_t w;
    run('0, -1, -1, e0);
    tests += 4;
    if (wr_cnt !== 104) begin fails++; $display("FAIL zk_writes got %0d exp 104", wr_cnt); end
    if (done_cnt !== 1) begin fails++; $display("FAIL zk_done_cnt got %0d exp 1", done_cnt); end
    if (done_cyc !== e0 + DL) begin fails++; $display("FAIL zk_done_cyc got %0d exp %0d", done_cyc - e0, DL); end
    if (got_q.size() < 27) begin fails++; $display("FAIL zk_qsize got %0d exp 104", got_q.size()); end
    else begin
      tests += 4;
      if (got_q[0] !== {5'd0, 32'hB7E15163}) begin fails++; $display("FAIL zk_w0 got %h exp 0:b7e15163", got_q[0]); end
      if (got_q[1] !== {5'd1, 32'h5618CB1C}) begin fails++; $display("FAIL zk_w1 got %h exp 1:5618cb1c", got_q[1]); end
      if (got_q[25] !== {5'd25, 32'h2B4C3474}) begin fails++; $display("FAIL zk_w25 got %h exp 25:2b4c3474", got_q[25]); end
      if (got_q[26] !== {5'd0, 32'hBF0A8B1D}) begin fails++; $display("FAIL zk_w26 got %h exp 0:bf0a8b1d", got_q[26]); end
    end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = got_q.pop_front();
      tests++;
      if (w !== exp_q[0]) begin fails++; $display("FAIL zk_sb got %h exp %h", w, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    tests++;
    if (ram !== ms) begin fails++; $display("FAIL zk_table got s0=%h s25=%h exp s0=%h s25=%h", ram[0], ram[25], ms[0], ms[25]); end
  endtask

  task automatic test_reference;
    int e0;
    wr_t w;
    logic [31:0] c0, c1, q0, q1;
    run(128'hFFFEEEE58684FFF05FFE493853000434, -1, -1, e0);
    tests += 2;
    if (wr_cnt !== 104) begin fails++; $display("FAIL ref_writes got %0d exp 104", wr_cnt); end
    if (exp_q.size() != got_q.size()) begin fails++; $display("FAIL ref_qsize got %0d exp %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = got_q.pop_front();
      tests++;
      if (w !== exp_q[0]) begin fails++; $display("FAIL ref_sb got %h exp %h", w, exp_q[0]); end
      void'(exp_q.pop_front());
    end
    for (int x = 0; x < 26; x++) begin
      tests++;
      if (ram[x] !== ms[x]) begin fails++; $display("FAIL ref_S[%0d] got %h exp %h", x, ram[x], ms[x]); end
    end
    encrypt(ms, 32'd10, 32'd20, c0, c1);
    decrypt(ram, c0, c1, q0, q1);
    tests++;
    if ({q0, q1} !== {32'd10, 32'd20}) begin fails++; $display("FAIL ref_roundtrip got %0d,%0d exp 10,20", q0, q1); end
  endtask

  task automatic test_start_busy;
    int e0;
    wr_t w;
    run(128'h0123456789ABCDEFFEDCBA9876543210, 27 + 40, DL, e0);
    tests += 4;
    if (wr_cnt !== 104) begin fails++; $display("FAIL busy_writes got %0d exp 104", wr_cnt); end
    if (done_cnt !== 1) begin fails++; $display("FAIL busy_done_cnt got %0d exp 1", done_cnt); end
    if (done_cyc !== e0 + DL) begin fails++; $display("FAIL busy_done_cyc got %0d exp %0d", done_cyc - e0, DL); end
    if (busy !== 1'b0) begin fails++; $display("FAIL busy_after_done got %b exp 0", busy); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = got_q.pop_front();
      tests++;
      if (w !== exp_q[0]) begin fails++; $display("FAIL busy_sb got %h exp %h", w, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  task automatic test_reset_mid;
    int e0, n;
    wr_t w;
    got_q.delete();
    wr_cnt = 0; done_cnt = 0;
    @(negedge clk);
    key = 128'hDEADBEEF; start = 1;
    @(posedge clk);
    #1 e0 = cyc;
    start = 0;
    while (cyc < e0 + 37) @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    tests++;
    if ({s_we, busy, s_addr} !== '0) begin fails++; $display("FAIL mid_rst_out got we=%b busy=%b addr=%0d exp 0", s_we, busy, s_addr); end
    n = wr_cnt;
    repeat (10) @(negedge clk);
    tests++;
    if (wr_cnt !== n || done_cnt !== 0) begin fails++; $display("FAIL mid_rst_quiet got writes=%0d done=%0d exp %0d,0", wr_cnt, done_cnt, n); end
    run(128'h00112233445566778899AABBCCDDEEFF, -1, -1, e0);
    tests += 3;
    if (wr_cnt !== 104) begin fails++; $display("FAIL mid_writes got %0d exp 104", wr_cnt); end
    if (done_cyc !== e0 + DL) begin fails++; $display("FAIL mid_done_cyc got %0d exp %0d", done_cyc - e0, DL); end
    if (ram !== ms) begin fails++; $display("FAIL mid_table got s0=%h exp s0=%h", ram[0], ms[0]); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      w = got_q.pop_front();
      tests++;
      if (w !== exp_q[0]) begin fails++; $display("FAIL mid_sb got %h exp %h", w, exp_q[0]); end
      void'(exp_q.pop_front());
    end
  endtask

  initial begin
    test_reset;
    test_init_mix;
    test_reference;
    test_start_busy;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
